// File: rtl/mips_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mips_pkg
// Description : Shared definitions for the instruction fetch path: datapath
//               width, default reset address and the fetch FSM state type.
// Revision    : 1.0 - initial release
// ============================================================================
package mips_pkg;

    localparam int unsigned XLEN = 32;

    // First fetch address after reset unless overridden on the instance.
    localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_0000;

    // RUN   : normal fetching.
    // DRAIN : a redirect left stale requests in flight; their responses are
    //         dropped and no new requests go out until they have all returned.
    typedef enum logic [0:0] {
        ST_RUN   = 1'b0,
        ST_DRAIN = 1'b1
    } fetch_state_e;

endpackage : mips_pkg
`default_nettype wire

// File: rtl/fetch_fifo.sv
`default_nettype none
// ============================================================================
// Module      : fetch_fifo
// Description : Instruction buffer holding {pc, instruction} pairs. The head
//               entry is visible combinationally on data_o. A push and a pop
//               may occur in the same cycle even when full.
// Ports       : clk, reset     - clock, synchronous active-high reset
//               flush_i        - empty the buffer (wins over push/pop)
//               push_i, data_i - write an entry at the tail
//               pop_i          - remove the head entry
//               data_o         - head entry
//               full_o, empty_o, count_o - occupancy status
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_fifo #(
    parameter int unsigned DEPTH = 2
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         flush_i,
    input  logic                         push_i,
    input  logic [63:0]                  data_i,
    input  logic                         pop_i,
    output logic [63:0]                  data_o,
    output logic                         full_o,
    output logic                         empty_o,
    output logic [$clog2(DEPTH+1)-1:0]   count_o
);
    localparam int unsigned CW = $clog2(DEPTH + 1);
    localparam int unsigned PW = $clog2(DEPTH);

    logic [63:0]   mem_q [DEPTH];
    logic [PW-1:0] rd_q;
    logic [PW-1:0] wr_q;
    logic [CW-1:0] count_q;
    logic          w_do_push;
    logic          w_do_pop;

    // Pointers wrap explicitly so non-power-of-two depths work.
    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign empty_o   = (count_q == '0);
    assign full_o    = (count_q == CW'(DEPTH));
    assign count_o   = count_q;
    assign data_o    = mem_q[rd_q];
    assign w_do_pop  = pop_i & ~empty_o;
    // A full buffer can still accept a push when the head leaves this cycle.
    assign w_do_push = push_i & (~full_o | w_do_pop);

    always_ff @(posedge clk) begin
        if (reset || flush_i) begin
            rd_q    <= '0;
            wr_q    <= '0;
            count_q <= '0;
        end else begin
            if (w_do_push) begin
                mem_q[wr_q] <= data_i;
                wr_q        <= ptr_inc(wr_q);
            end
            if (w_do_pop) begin
                rd_q <= ptr_inc(rd_q);
            end
            count_q <= count_q + CW'(w_do_push) - CW'(w_do_pop);
        end
    end

endmodule : fetch_fifo
`default_nettype wire

// File: rtl/fetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : fetch_unit
// Description : Sequential instruction fetcher. Issues word-aligned reads,
//               tags in-order responses with their request address, buffers
//               them in fetch_fifo and offers them to decode. Redirects flush
//               the buffer and drop responses of requests still in flight.
// Ports       : clk, reset                              - clock, sync reset
//               imem_req_valid/addr/ready               - memory request
//               imem_resp_valid/data                    - memory response
//               redirect_valid/pc                       - core redirect
//               inst_valid/data/pc/ready                - decode handshake
//               perf_fetched, perf_stall                - FETCH_PERF_EN only
// Options     : define FETCH_PERF_EN to add the performance counters.
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_unit
    import mips_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEFAULT,
    parameter int unsigned     DEPTH    = 2
) (
    input  logic            clk,
    input  logic            reset,
    output logic            imem_req_valid,
    output logic [XLEN-1:0] imem_req_addr,
    input  logic            imem_req_ready,
    input  logic            imem_resp_valid,
    input  logic [XLEN-1:0] imem_resp_data,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            inst_valid,
    output logic [XLEN-1:0] inst_data,
    output logic [XLEN-1:0] inst_pc,
    input  logic            inst_ready
`ifdef FETCH_PERF_EN
    ,
    output logic [31:0]     perf_fetched,
    output logic [31:0]     perf_stall
`endif
);
    localparam int unsigned CW = $clog2(DEPTH + 1);
    localparam int unsigned PW = $clog2(DEPTH);

    fetch_state_e    state_q,    state_d;
    logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
    logic [CW-1:0]   outst_q,    outst_d;
    logic [CW-1:0]   discard_q,  discard_d;
    logic [XLEN-1:0] aq_mem_q [DEPTH];
    logic [PW-1:0]   aq_wr_q;
    logic [PW-1:0]   aq_rd_q;

    logic            w_accept;
    logic            w_resp;
    logic            w_push;
    logic            w_pop;
    logic            w_room;
    logic [CW:0]     w_occupancy;
    logic [63:0]     w_head;
    logic            w_fifo_full;
    logic            w_fifo_empty;
    logic [CW-1:0]   w_fifo_count;
    logic            w_unused_ok;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    // A response is only meaningful while something is in flight; anything
    // else (e.g. a late reply to a request issued before reset) is ignored.
    assign w_resp = imem_resp_valid & ~reset & (outst_q != '0);

    assign inst_valid = ~reset & ~w_fifo_empty;
    assign inst_pc    = w_head[63:32];
    assign inst_data  = w_head[31:0];

    // Redirect beats pop and push in the same cycle.
    assign w_pop  = inst_valid & inst_ready & ~redirect_valid;
    assign w_push = w_resp & (discard_q == '0) & ~redirect_valid;

    // The entry leaving the buffer this cycle frees a slot for a new request,
    // which sustains one instruction per cycle even with a two-entry buffer.
    assign w_occupancy = {1'b0, w_fifo_count} + {1'b0, outst_q} - (CW+1)'(w_pop);
    assign w_room      = (w_occupancy < (CW+1)'(DEPTH));

    assign imem_req_valid = ~reset & ~redirect_valid & (state_q == ST_RUN) & w_room;
    assign imem_req_addr  = fetch_pc_q;
    assign w_accept       = imem_req_valid & imem_req_ready;

    always_comb begin
        fetch_pc_d = fetch_pc_q;
        outst_d    = outst_q + CW'(w_accept) - CW'(w_resp);
        discard_d  = discard_q;
        state_d    = state_q;

        if (redirect_valid) begin
            // No request can be accepted in a redirect cycle, so everything
            // still outstanding after this cycle's response must be dropped.
            fetch_pc_d = {redirect_pc[XLEN-1:2], 2'b00};
            discard_d  = outst_q - CW'(w_resp);
            state_d    = (discard_d != '0) ? ST_DRAIN : ST_RUN;
        end else begin
            if (w_accept) begin
                fetch_pc_d = fetch_pc_q + 32'd4;
            end
            if (w_resp && (discard_q != '0)) begin
                discard_d = discard_q - 1'b1;
            end
            if ((state_q == ST_DRAIN) && (discard_d == '0)) begin
                state_d = ST_RUN;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_RUN;
            fetch_pc_q <= RESET_PC;
            outst_q    <= '0;
            discard_q  <= '0;
            aq_wr_q    <= '0;
            aq_rd_q    <= '0;
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            outst_q    <= outst_d;
            discard_q  <= discard_d;
            // Request-address queue tracks every accepted request, including
            // ones whose responses will be discarded, to stay in step.
            if (w_accept) begin
                aq_mem_q[aq_wr_q] <= fetch_pc_q;
                aq_wr_q           <= ptr_inc(aq_wr_q);
            end
            if (w_resp) begin
                aq_rd_q <= ptr_inc(aq_rd_q);
            end
        end
    end

    fetch_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .flush_i (redirect_valid),
        .push_i  (w_push),
        .data_i  ({aq_mem_q[aq_rd_q], imem_resp_data}),
        .pop_i   (w_pop),
        .data_o  (w_head),
        .full_o  (w_fifo_full),
        .empty_o (w_fifo_empty),
        .count_o (w_fifo_count)
    );

    // Low redirect bits are forced to zero; full status is implied by count.
    assign w_unused_ok = &{1'b0, redirect_pc[1:0], w_fifo_full};

`ifdef FETCH_PERF_EN
    logic [31:0] perf_fetched_q;
    logic [31:0] perf_stall_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            perf_fetched_q <= '0;
            perf_stall_q   <= '0;
        end else begin
            if (w_pop && (perf_fetched_q != 32'hFFFF_FFFF)) begin
                perf_fetched_q <= perf_fetched_q + 32'd1;
            end
            if (inst_ready && !inst_valid && (perf_stall_q != 32'hFFFF_FFFF)) begin
                perf_stall_q <= perf_stall_q + 32'd1;
            end
        end
    end

    assign perf_fetched = perf_fetched_q;
    assign perf_stall   = perf_stall_q;
`endif

endmodule : fetch_unit
`default_nettype wire
